ascon_tag_verify: RTL

Release gate for the Ascon decryption path. It takes the plaintext and recomputed tag from the decryption core, and the tag received with the ciphertext. It compares the two tags in constant time, chunk by chunk, using two complementary accumulators as a fault countermeasure, and releases the plaintext only on a verified match. It sits directly after the `dec_plain_text` / `dec_tag` / `decryption_ready` outputs of the fault-countermeasure wrapper.

---
 rtl/ascon_tag_verify.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ascon_tag_verify.sv
// Ascon decryption release gate: constant-time chunked tag compare with dual
// complementary accumulators; plaintext is released only on a consistent match.
module ascon_tag_verify #(
  parameter int y = 40,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [y-1:0]   dec_plain_text,
  input  logic [127:0]   dec_tag,
  input  logic [127:0]   expected_tag,
  input  logic           decryption_ready,
  output logic [y-1:0]   plain_text_out,
  output logic           valid,
  output logic           auth_fail,
  output logic           busy,
  output logic           fault_alarm
);
  localparam int N    = 128 / W;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_CMP    = 4'b0010;
  localparam logic [3:0] S_DECIDE = 4'b0100;
  localparam logic [3:0] S_DONE   = 4'b1000;

  logic [3:0]            state, state_nx;
  logic                  ready_q, start, illegal;
  logic [IDXW-1:0]       idx;
  logic [y-1:0]          pt_r;
  logic [N-1:0][W-1:0]   tag_a_r, tag_b_r, d_chunk;
  logic [W-1:0]          d, acc_a, acc_b;
  logic                  ma, mb, last;

  assign start = decryption_ready & ~ready_q;

  for (genvar g = 0; g < N; g++) begin : g_chunk
    assign d_chunk[g] = tag_a_r[g] ^ tag_b_r[g];
  end

  // Explicit mux keeps the chunk select well-formed for any N, including N=1.
  always_comb begin
    d = '0;
    for (int i = 0; i < N; i++)
      if (idx == IDXW'(i)) d = d_chunk[i];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_CMP;
      S_CMP:    if (!decryption_ready) state_nx = S_IDLE;
                else if (last)         state_nx = S_DECIDE;
      S_DECIDE: state_nx = S_DONE;
      S_DONE:   if (!decryption_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    illegal = !$onehot(state);
    busy    = (state == S_CMP) || (state == S_DECIDE);
    last    = (idx == IDXW'(N - 1));
    ma      = (acc_a == '0);
    mb      = (acc_b == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q        <= 1'b0;
      idx            <= '0;
      pt_r           <= '0;
      tag_a_r        <= '0;
      tag_b_r        <= '0;
      acc_a          <= '0;
      acc_b          <= '0;
      plain_text_out <= '0;
      valid          <= 1'b0;
      auth_fail      <= 1'b0;
      fault_alarm    <= 1'b0;
    end else begin
      ready_q <= decryption_ready;
      if (illegal || ((state == S_CMP) && !decryption_ready) ||
          ((state == S_DONE) && !decryption_ready)) begin
        // Corrupted state, abort or release: drop everything back to zero.
        if (illegal) fault_alarm <= 1'b1;
        idx            <= '0;
        pt_r           <= '0;
        tag_a_r        <= '0;
        tag_b_r        <= '0;
        acc_a          <= '0;
        acc_b          <= '0;
        plain_text_out <= '0;
        valid          <= 1'b0;
        auth_fail      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            pt_r    <= dec_plain_text;
            tag_a_r <= dec_tag;
            tag_b_r <= expected_tag;
            idx     <= '0;
            acc_a   <= '0;
            acc_b   <= '1;
          end
          S_CMP: begin
            acc_a <= acc_a | d;
            acc_b <= acc_b & ~d;
            idx   <= idx + IDXW'(1);
          end
          S_DECIDE: begin
            // Disagreeing accumulators mean one path was tampered with.
            if (ma != mb) begin
              fault_alarm <= 1'b1;
              auth_fail   <= 1'b1;
            end else if (ma && !fault_alarm) begin
              valid          <= 1'b1;
              plain_text_out <= pt_r;
            end else begin
              auth_fail <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
